// File: rtl/sv32_ptw.sv
// sv32_ptw: Sv32 two-level page-table walker feeding the TLB fill port.
// Define PTW_AD_CHECK_EN to fault on leaves with A=0, or with D=0 on a store walk.
module sv32_ptw #(
    parameter int PTE_WIDTH   = 32,
    parameter int PADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   walk_req_i,
    input  logic [31:0]            walk_vaddr_i,
    input  logic                   walk_store_i,
    output logic                   walk_ready_o,
    output logic                   walk_done_o,
    output logic                   walk_fault_o,
    input  logic [21:0]            satp_ppn_i,
    input  logic                   flush_all_i,
    output logic                   mem_req_o,
    output logic [PADDR_WIDTH-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [PTE_WIDTH-1:0]   mem_rdata_i,
    output logic                   fill_req_o,
    output logic [19:0]            fill_vpn_o,
    output logic [21:0]            fill_ppn_o,
    output logic [6:0]             fill_perm_o,
    output logic                   fill_superpage_o
);
    typedef enum logic [2:0] {IDLE, L1_REQ, L1_CHK, L0_REQ, L0_CHK, DONE} state_e;

    state_e         state_q, state_d;
    logic [19:0]    vpn_q, vpn_d;
    logic [31:0]    pte_q, pte_d;
    logic           store_q, store_d;
    logic           kill_q, kill_d;
    logic           fault_q, fault_d;
    logic           super_q, super_d;
    logic           kill, bad, leaf, misal, ad_bad, done, unused_ok;

    assign kill  = kill_q | flush_all_i;
    assign bad   = ~pte_q[0] | (~pte_q[1] & pte_q[2]);
    assign leaf  = pte_q[1] | pte_q[3];
    assign misal = |pte_q[19:10];
`ifdef PTW_AD_CHECK_EN
    assign ad_bad = ~pte_q[6] | (store_q & ~pte_q[7]);
`else
    assign ad_bad = 1'b0;
`endif
    // RSW bits, page offset and the top of satp (beyond 32-bit PA) are not needed
    assign unused_ok = ^{pte_q[9:8], walk_vaddr_i[11:0], satp_ppn_i[21:20], store_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vpn_q   <= '0;
            pte_q   <= '0;
            store_q <= 1'b0;
            kill_q  <= 1'b0;
            fault_q <= 1'b0;
            super_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
            pte_q   <= pte_d;
            store_q <= store_d;
            kill_q  <= kill_d;
            fault_q <= fault_d;
            super_q <= super_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vpn_d   = vpn_q;
        pte_d   = pte_q;
        store_d = store_q;
        fault_d = fault_q;
        super_d = super_q;
        kill_d  = (state_q == IDLE) ? 1'b0 : kill;
        case (state_q)
            IDLE: if (walk_req_i) begin
                state_d = L1_REQ;
                vpn_d   = walk_vaddr_i[31:12];
                store_d = walk_store_i;
            end
            L1_REQ, L0_REQ: if (mem_ack_i) begin
                pte_d   = mem_rdata_i;
                state_d = kill ? DONE : (state_q == L1_REQ ? L1_CHK : L0_CHK);
            end
            L1_CHK: begin
                fault_d = bad | (leaf & (misal | ad_bad));
                super_d = leaf;
                state_d = (kill | bad | leaf) ? DONE : L0_REQ;
            end
            L0_CHK: begin
                fault_d = bad | ~leaf | ad_bad;
                super_d = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign done             = state_q == DONE;
    assign walk_ready_o     = state_q == IDLE;
    assign walk_done_o      = done;
    assign walk_fault_o     = done & ~kill & fault_q;
    assign fill_req_o       = done & ~kill & ~fault_q;
    assign fill_vpn_o       = fill_req_o ? vpn_q : '0;
    assign fill_ppn_o       = fill_req_o ? pte_q[31:10] : '0;
    assign fill_perm_o      = fill_req_o ? pte_q[7:1] : '0;
    assign fill_superpage_o = fill_req_o & super_q;
    assign mem_req_o        = (state_q == L1_REQ) | (state_q == L0_REQ);
    assign mem_addr_o       = (state_q == L1_REQ) ? {satp_ppn_i[19:0], vpn_q[19:10], 2'b00} :
                              (state_q == L0_REQ) ? {pte_q[29:10], vpn_q[9:0], 2'b00} : '0;
endmodule

// File: tb/tb_sv32_ptw.sv
// tb_sv32_ptw: randomized walks against a rule-level Sv32 walk model with a reactive memory.
module tb_sv32_ptw;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        walk_req = 1'b0, walk_store = 1'b0, flush_all = 1'b0, mem_ack = 1'b0;
    logic [31:0] walk_vaddr = '0, mem_rdata = '0;
    logic [21:0] satp_ppn = '0;
    logic        walk_ready_o, walk_done_o, walk_fault_o, mem_req_o, fill_req_o, fill_superpage_o;
    logic [31:0] mem_addr_o;
    logic [19:0] fill_vpn_o;
    logic [21:0] fill_ppn_o;
    logic [6:0]  fill_perm_o;
    int n_cmp = 0, n_bad = 0;

    sv32_ptw dut (
        .clk(clk), .rst_n(rst_n), .walk_req_i(walk_req), .walk_vaddr_i(walk_vaddr),
        .walk_store_i(walk_store), .walk_ready_o(walk_ready_o), .walk_done_o(walk_done_o),
        .walk_fault_o(walk_fault_o), .satp_ppn_i(satp_ppn), .flush_all_i(flush_all),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata), .fill_req_o(fill_req_o), .fill_vpn_o(fill_vpn_o),
        .fill_ppn_o(fill_ppn_o), .fill_perm_o(fill_perm_o), .fill_superpage_o(fill_superpage_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit pte_ok(input logic [31:0] p);
        return p[0] && !(!p[1] && p[2]);
    endfunction

    function automatic bit pte_leaf(input logic [31:0] p);
        return p[1] || p[3];
    endfunction

    function automatic bit ad_fault(input logic [31:0] p, input bit st);
`ifdef PTW_AD_CHECK_EN
        return !p[6] || (st && !p[7]);
`else
        return (p[6] & st) & 1'b0;
`endif
    endfunction

    function automatic logic [31:0] gen_pte(input bit l1);
        logic [31:0] p = $urandom;
        int k = $urandom_range(0, 7);
        if (k != 0) p[0] = 1'b1;
        if (k == 1) p[2:1] = 2'b10;
        if (l1 && k >= 5) p[3:1] = 3'b000;
        if (l1 && $urandom_range(0, 1) == 1) p[19:10] = '0;
        if (!l1 && k >= 3) p[1] = 1'b1;
        return p;
    endfunction

    // fl_at: cycle after acceptance at which flush_all is pulsed (0 = never)
    task automatic run_walk(input logic [21:0] satp, input logic [31:0] va, input bit st,
                            input logic [31:0] p1, input logic [31:0] p0,
                            input int w1, input int w2, input int fl_at);
        int lv, lat, lvl, waited, c;
        bit exp_fault, exp_super, done, killed;
        logic [31:0] a1, a0, leafpte;
        a1 = {satp[19:0], va[31:22], 2'b00};
        a0 = {p1[29:10], va[21:12], 2'b00};
        lv = 1; exp_super = 0; leafpte = p1;
        if (!pte_ok(p1)) exp_fault = 1;
        else if (pte_leaf(p1)) begin
            exp_fault = (p1[19:10] != 0) || ad_fault(p1, st);
            exp_super = 1;
        end else begin
            lv = 2; leafpte = p0;
            exp_fault = !pte_ok(p0) || !pte_leaf(p0) || ad_fault(p0, st);
        end
        lat = (lv == 1) ? 3 + w1 : 5 + w1 + w2;
        @(negedge clk);
        satp_ppn = satp; walk_vaddr = va; walk_store = st; walk_req = 1'b1;
        #1 check("ready_idle", walk_ready_o, 1);
        @(negedge clk);
        walk_req = 1'b0;
        lvl = 1; waited = 0; done = 0; killed = 0;
        for (c = 1; c < 60 && !done; c++) begin
            if (c > 1) @(negedge clk);
            flush_all = (c == fl_at);
            mem_ack = 1'b0;
            #1;
            if (flush_all && !walk_ready_o) killed = 1;
            if (mem_req_o) begin
                if (lvl > lv) check("req_level", lvl, lv);
                check(lvl == 1 ? "addr_l1" : "addr_l0", mem_addr_o, lvl == 1 ? a1 : a0);
                if (waited == (lvl == 1 ? w1 : w2)) begin
                    mem_ack = 1'b1; mem_rdata = (lvl == 1) ? p1 : p0;
                    lvl++; waited = 0;
                end else waited++;
            end
            check("ready_busy", walk_ready_o, 0);
            if (!fill_req_o)
                check("fill_zero", {fill_vpn_o, fill_ppn_o, fill_perm_o, fill_superpage_o}, 0);
            if (walk_done_o) begin
                done = 1;
                if (killed) begin
                    check("kill_fault", walk_fault_o, 0);
                    check("kill_fill", fill_req_o, 0);
                end else begin
                    check("latency", c, lat);
                    check("fault", walk_fault_o, exp_fault);
                    check("fill_req", fill_req_o, !exp_fault);
                    if (!exp_fault) begin
                        check("fill_vpn", fill_vpn_o, va[31:12]);
                        check("fill_ppn", fill_ppn_o, leafpte[31:10]);
                        check("fill_perm", fill_perm_o, leafpte[7:1]);
                        check("fill_super", fill_superpage_o, exp_super);
                    end
                end
            end
        end
        check("done_seen", done, 1);
        @(negedge clk);
        flush_all = 1'b0; mem_ack = 1'b0;
        #1 check("ready_after", walk_ready_o, 1);
        check("done_after", walk_done_o, 0);
    endtask

    initial begin
        #1;
        check("rst_ready", walk_ready_o, 1);
        check("rst_outs", {walk_done_o, walk_fault_o, mem_req_o, fill_req_o}, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_fill", {fill_vpn_o, fill_ppn_o, fill_perm_o, fill_superpage_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_walk(22'h80, 32'h4000_1234, 0, 32'h2000_00CF, 0, 0, 0, 0);
        run_walk(22'h80, 32'h4000_1234, 0, 32'h0002_0401, 32'h048D_14CB, 0, 0, 0);
        run_walk(22'h80, 32'h4000_1234, 0, 32'h0000_0000, 0, 0, 0, 0);
        run_walk(22'h80, 32'h4000_1234, 0, 32'h2000_04CF, 0, 0, 0, 0);
        run_walk(22'h80, 32'h4000_1234, 0, 32'h0002_0401, 32'h0000_0001, 0, 0, 0);
        run_walk(22'h80, 32'h4000_1234, 0, 32'h2000_00CF, 0, 3, 0, 0);
        run_walk(22'h80, 32'h4000_1234, 0, 32'h2000_00CF, 0, 3, 0, 2);
        run_walk(22'h80, 32'h4000_1234, 0, 32'h0002_0401, 32'h048D_14CB, 0, 0, 5);
        run_walk(22'h80, 32'h4000_1234, 1, 32'h0002_0401, 32'h048D_144B, 0, 0, 0);
        // flush while idle must not disturb the following walk
        @(negedge clk); flush_all = 1'b1;
        @(negedge clk); flush_all = 1'b0;
        run_walk(22'h80, 32'h4000_1234, 0, 32'h2000_00CF, 0, 1, 0, 0);
        // reset asserted while waiting in L0_REQ
        @(negedge clk);
        satp_ppn = 22'h80; walk_vaddr = 32'h4000_1234; walk_req = 1'b1;
        @(negedge clk);
        walk_req = 1'b0;
        #1 mem_ack = 1'b1; mem_rdata = 32'h0002_0401;
        @(negedge clk); mem_ack = 1'b0;
        @(negedge clk);
        #1 check("pre_rst_req", mem_req_o, 1);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_req", mem_req_o, 0);
        check("mid_rst_ready", walk_ready_o, 1);
        check("mid_rst_done", walk_done_o, 0);
        @(negedge clk); rst_n = 1'b1;
        run_walk(22'h80, 32'h4000_1234, 0, 32'h0002_0401, 32'h048D_14CB, 1, 2, 0);
        for (int i = 0; i < 300; i++)
            run_walk(22'($urandom), $urandom, 1'($urandom_range(0, 1)), gen_pte(1), gen_pte(0),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sv32_ptw.md
Name: sv32_ptw

Overview:
- Sv32 hardware page-table walker, directly upstream of the 32-entry fully-associative TLB.
- On a TLB miss it reads up to two PTEs from memory and validates the leaf.
- A valid leaf drives the TLB fill port (vpn/ppn/perm/superpage); an invalid PTE reports a page fault.
- One walk in flight at a time; single blocking memory read port.

Parameters:
- PTE_WIDTH, 32, width of a page-table entry and of mem_rdata_i.
- PADDR_WIDTH, 32, physical address width driven on mem_addr_o (low bits of the Sv32 34-bit address).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- walk_req_i  input  1  miss request; accepted when walk_ready_o=1.
- walk_vaddr_i  input  32  faulting virtual address.
- walk_store_i  input  1  access is a store (used only by the optional feature).
- walk_ready_o  output  1  high only in IDLE.
- walk_done_o  output  1  one-cycle pulse at walk end (fill, fault or abort).
- walk_fault_o  output  1  page fault, qualified by walk_done_o.
- satp_ppn_i  input  22  root page-table PPN.
- flush_all_i  input  1  SFENCE.VMA; kills any walk in flight.
- mem_req_o  output  1  PTE read request.
- mem_addr_o  output  32  PTE byte address.
- mem_ack_i  input  1  read complete; mem_rdata_i is valid in the same cycle.
- mem_rdata_i  input  32  PTE data.
- fill_req_o  output  1  TLB fill strobe, one cycle.
- fill_vpn_o  output  20  walk_vaddr[31:12].
- fill_ppn_o  output  22  PTE[31:10].
- fill_perm_o  output  7  PTE[7:1] = {D,A,G,U,X,W,R}.
- fill_superpage_o  output  1  leaf found at level 1.

Behaviour:
- Reset: state=IDLE; all outputs 0 except walk_ready_o=1; internal vaddr/PTE registers cleared.
- States: IDLE, L1_REQ, L1_CHK, L0_REQ, L0_CHK, DONE.
- IDLE
  - On walk_req_i, capture the vaddr and store bit, clear the kill flag, go to L1_REQ.
  - satp_ppn_i is sampled in L1_REQ only.
- L1_REQ
  - mem_req_o=1, mem_addr_o={satp_ppn[19:0], vpn1, 2'b00}.
  - Request and address are held stable until mem_ack_i.
  - On ack, register mem_rdata_i and go to L1_CHK. mem_req_o drops the next cycle.
- L1_CHK
  - V=0, or (R=0 and W=1): fault → DONE.
  - Leaf (R|X): if PTE[19:10]≠0 (misaligned superpage), fault; otherwise superpage fill. Either way → DONE.
  - Otherwise (pointer): → L0_REQ with mem_addr_o={PTE[29:10], vpn0, 2'b00}.
- L0_REQ: same handshake as L1_REQ → L0_CHK.
- L0_CHK
  - V=0, or (R=0 and W=1), or non-leaf: fault.
  - Otherwise 4 KB fill.
  - → DONE.
- DONE (one cycle)
  - walk_done_o=1.
  - Either walk_fault_o=1, or fill_req_o=1 with fill_* valid.
  - Fill and fault are mutually exclusive.
  - → IDLE. walk_ready_o=1 the following cycle.
- Latency with zero-wait memory (request accepted at T):
  - mem_req_o at T+1.
  - Superpage or L1 fault: DONE at T+3.
  - 4 KB leaf or L0 fault: DONE at T+5.
  - Each wait cycle on mem_ack_i adds one cycle.
- fill_* outputs are zero whenever fill_req_o=0.
- flush_all_i
  - In IDLE: no effect.
  - In any busy state: sets a sticky kill flag.
  - An outstanding memory request is never withdrawn; it completes its handshake.
  - The FSM then goes straight to DONE (skipping remaining levels) with fill_req_o=0 and walk_fault_o=0.
  - flush_all_i in the DONE cycle itself also suppresses the fill.
- walk_req_i while busy is ignored; the requester holds it until walk_ready_o.
- rst_n asserted mid-walk: immediate return to reset values. The memory side must tolerate a dropped mem_req_o.

Optional Feature:
- Macro: PTW_AD_CHECK_EN.
- Defined:
  - A leaf with A=0 faults.
  - A leaf with walk_store=1 and D=0 faults.
  - Applies at both levels.
- Undefined: the A and D bits are passed through in fill_perm_o and never cause a fault.

Test Plan:
- Superpage: satp_ppn=0x00080, vaddr=0x4000_1234, ack 0x2000_00CF at address 0x0008_0400 → DONE at T+3, fill_vpn=0x40001, fill_ppn=0x80000, perm=0x67, superpage=1, fault=0.
- 4 KB page: same vaddr; L1 data 0x0002_0401, L0 access at address 0x0008_1004 returns 0x048D_14CB → DONE at T+5, fill_ppn=0x12345, perm=0x65, superpage=0.
- Faults:
  - L1 data 0x0000_0000 → walk_fault_o=1, no fill.
  - Misaligned superpage 0x2000_04CF → fault.
  - L0 pointer PTE 0x0000_0001 → fault.
- Wait states and kill:
  - mem_ack_i delayed 3 cycles → mem_addr_o stable throughout, done at T+6 (superpage).
  - flush_all_i pulsed during L1 wait → ack still consumed, done pulse with fill=0 and fault=0.
- Reset mid-walk: deassert rst_n in L0_REQ → mem_req_o=0 and walk_ready_o=1 immediately; a new walk afterwards completes correctly.
- With PTW_AD_CHECK_EN: store walk, L0 leaf 0x048D_144B (D=0) → fault. Without the macro: fill with perm=0x25.
